// File: rtl/analog_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : analog_io_pkg
// Description : Register map constants and helpers shared by the analog I/O bank.
// Revision    : 1.0 - initial release
// ============================================================================
package analog_io_pkg;

    localparam int unsigned c_REG_DIR    = 0;
    localparam int unsigned c_REG_STATUS = 1;
    localparam int unsigned c_CH_BASE    = 2;

    typedef enum logic [1:0] {
        REG_OUT = 2'd0,
        REG_IN  = 2'd1,
        REG_LO  = 2'd2,
        REG_HI  = 2'd3
    } chan_reg_e;

    // OUT/IN pairs follow the fixed registers; LO/HI pairs follow all OUT/IN pairs.
    function automatic int unsigned chan_addr(input int unsigned ch,
                                              input chan_reg_e   kind,
                                              input int unsigned channels);
        int unsigned a;
        case (kind)
            REG_OUT: a = c_CH_BASE + 2 * ch;
            REG_IN:  a = c_CH_BASE + 2 * ch + 1;
            REG_LO:  a = c_CH_BASE + 2 * channels + 2 * ch;
            default: a = c_CH_BASE + 2 * channels + 2 * ch + 1;
        endcase
        return a;
    endfunction

    function automatic int unsigned acc_width(input int unsigned bits,
                                              input int unsigned avg_log2);
        return bits + avg_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/analog_io_if.sv
`default_nettype none
// ============================================================================
// Module      : analog_io_if
// Description : Host register bus between the PLC core and the analog I/O bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface analog_io_if #(
    parameter int BITS   = 16,
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [BITS-1:0]   wdata;
    logic [BITS-1:0]   rdata;
    logic              rvalid;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/analog_io_chan.sv
`default_nettype none
// ============================================================================
// Module      : analog_io_chan
// Description : One analog channel: tristate driver, input synchroniser,
//               block-averaging accumulator and (with ANALOG_IO_LIMIT_EN)
//               limit alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module analog_io_chan
    import analog_io_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int AVG_LOG2 = 2
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              drive,
    input  wire [BITS-1:0]   out_val,
    input  wire              tick,
    input  wire              last,
`ifdef ANALOG_IO_LIMIT_EN
    input  wire [BITS-1:0]   lo,
    input  wire [BITS-1:0]   hi,
    output logic             alarm,
`endif
    output logic [BITS-1:0]  in_val,
    inout  wire  [BITS-1:0]  pin
);

    localparam int c_AW = acc_width(BITS, AVG_LOG2);

    logic [BITS-1:0] r_s1;
    logic [BITS-1:0] r_s2;
    logic [c_AW-1:0] r_acc;
    logic [BITS-1:0] r_in;
    logic [c_AW-1:0] w_sum;
    logic [BITS-1:0] w_avg;

    assign pin    = drive ? out_val : {BITS{1'bz}};
    assign in_val = r_in;

    // The last sample of a block is folded in on the same tick it is taken.
    assign w_sum = r_acc + c_AW'(r_s2);
    assign w_avg = w_sum[AVG_LOG2 +: BITS];

`ifdef ANALOG_IO_LIMIT_EN
    logic r_alarm;
    assign alarm = r_alarm;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_acc <= '0;
            r_in  <= '0;
`ifdef ANALOG_IO_LIMIT_EN
            r_alarm <= 1'b0;
`endif
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
            if (tick) begin
                if (last) begin
                    r_in  <= w_avg;
                    r_acc <= '0;
`ifdef ANALOG_IO_LIMIT_EN
                    r_alarm <= (w_avg < lo) | (w_avg > hi);
`endif
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/analog_io_bank.sv
`default_nettype none
// ============================================================================
// Module      : analog_io_bank
// Description : CHANNELS bidirectional analog converter buses behind one
//               register-mapped host port. Optional limit alarms are enabled
//               with the ANALOG_IO_LIMIT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module analog_io_bank
    import analog_io_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 8,
    parameter int AVG_LOG2 = 2,
    parameter int ADDR_W   = 6
) (
    input  wire                      clk,
    input  wire                      rst,
    analog_io_if.slave               bus,
    output logic [CHANNELS-1:0]      data_valid,
    output logic [CHANNELS-1:0]      alarm,
    inout  wire  [CHANNELS*BITS-1:0] io_port
);

    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [CHANNELS-1:0] r_dir;
    logic [BITS-1:0]     r_out [CHANNELS];
    logic [BITS-1:0]     w_in  [CHANNELS];
    logic [CHANNELS-1:0] r_valid;
    logic [c_PW-1:0]     r_pcnt;
    logic [c_SW-1:0]     r_scnt;
    logic                w_tick;
    logic                w_last;
    logic                w_status_rd;
    logic [BITS-1:0]     w_rd_word;
    logic [BITS-1:0]     r_rd_word;
    logic                r_rd_pend;

    assign w_tick      = (r_pcnt == c_PW'(PRESCALE - 1));
    assign w_last      = (r_scnt == c_SW'((1 << AVG_LOG2) - 1));
    assign w_status_rd = bus.rd_en && (bus.addr == ADDR_W'(c_REG_STATUS));
    assign data_valid  = r_valid;

    // Prescaler and sample counter shared by every channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_scnt <= '0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                r_scnt <= w_last ? '0 : r_scnt + 1'b1;
            end
        end
    end

    // A result update on the same edge as a STATUS read keeps the flags set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~{CHANNELS{w_status_rd}}) |
                       {CHANNELS{w_tick & w_last}};
        end
    end

`ifdef ANALOG_IO_LIMIT_EN
    logic [BITS-1:0] r_lo [CHANNELS];
    logic [BITS-1:0] r_hi [CHANNELS];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_out[c] <= '0;
`ifdef ANALOG_IO_LIMIT_EN
                r_lo[c] <= '0;
                r_hi[c] <= '1;
`endif
            end
        end else if (bus.wr_en) begin
            if (bus.addr == ADDR_W'(c_REG_DIR)) begin
                r_dir <= bus.wdata[CHANNELS-1:0];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.addr == ADDR_W'(chan_addr(c, REG_OUT, CHANNELS))) begin
                    r_out[c] <= bus.wdata;
                end
`ifdef ANALOG_IO_LIMIT_EN
                if (bus.addr == ADDR_W'(chan_addr(c, REG_LO, CHANNELS))) begin
                    r_lo[c] <= bus.wdata;
                end
                if (bus.addr == ADDR_W'(chan_addr(c, REG_HI, CHANNELS))) begin
                    r_hi[c] <= bus.wdata;
                end
`endif
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (bus.addr == ADDR_W'(c_REG_DIR)) begin
            w_rd_word[CHANNELS-1:0] = r_dir;
        end
        if (bus.addr == ADDR_W'(c_REG_STATUS)) begin
            w_rd_word[CHANNELS-1:0] = r_valid;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.addr == ADDR_W'(chan_addr(c, REG_OUT, CHANNELS))) begin
                w_rd_word = r_out[c];
            end
            if (bus.addr == ADDR_W'(chan_addr(c, REG_IN, CHANNELS))) begin
                w_rd_word = w_in[c];
            end
`ifdef ANALOG_IO_LIMIT_EN
            if (bus.addr == ADDR_W'(chan_addr(c, REG_LO, CHANNELS))) begin
                w_rd_word = r_lo[c];
            end
            if (bus.addr == ADDR_W'(chan_addr(c, REG_HI, CHANNELS))) begin
                w_rd_word = r_hi[c];
            end
`endif
        end
    end

    // Register contents are captured on the request edge so a same-cycle
    // write is not visible; the word is presented one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_word  <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            r_rd_pend  <= bus.rd_en;
            r_rd_word  <= w_rd_word;
            bus.rdata  <= r_rd_pend ? r_rd_word : '0;
            bus.rvalid <= r_rd_pend;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        analog_io_chan #(
            .BITS     (BITS),
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .drive   (r_dir[c]),
            .out_val (r_out[c]),
            .tick    (w_tick),
            .last    (w_last),
`ifdef ANALOG_IO_LIMIT_EN
            .lo      (r_lo[c]),
            .hi      (r_hi[c]),
            .alarm   (alarm[c]),
`endif
            .in_val  (w_in[c]),
            .pin     (io_port[c*BITS +: BITS])
        );
    end

`ifndef ANALOG_IO_LIMIT_EN
    assign alarm = '0;
`endif

endmodule
`default_nettype wire

// File: doc/analog_io_bank.md
Name: analog_io_bank

Overview:
- Multi-channel successor to the single-port analog I/O cell: CHANNELS independent BITS-wide bidirectional analog converter buses behind one register-mapped host interface.
- Each channel has a programmable direction, a registered output value and a synchronised input path.
- Each input path has a prescaled block-averaging filter.
- Sits between the PLC core's I/O bus and the external DAC/ADC parallel buses.

Parameters:
- BITS, 16, width of one channel's data bus.
- CHANNELS, 4, number of channels; 1..BITS (DIR and STATUS are packed into one word).
- PRESCALE, 8, clock cycles per sample tick; >=1.
- AVG_LOG2, 2, samples averaged per result = 2^AVG_LOG2; 0 = no averaging.
- ADDR_W, 6, host address width; must cover the full register map.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active high.
- wr_en  input  1  host write strobe.
- rd_en  input  1  host read strobe.
- addr  input  ADDR_W  register address.
- wdata  input  BITS  write data.
- rdata  output  BITS  read data, registered.
- rvalid  output  1  one-cycle pulse qualifying rdata.
- data_valid  output  CHANNELS  per-channel "new average available" flags (mirror of STATUS).
- alarm  output  CHANNELS  limit alarms (see Optional Feature).
- io_port  inout  CHANNELS*BITS  channel c on bits [c*BITS +: BITS].

Behaviour:
- Register map:
  - 0 = DIR: bit c = 1 drives channel c.
  - 1 = STATUS: valid flags, read-to-clear.
  - 2+2c = OUT[c]: read/write.
  - 3+2c = IN[c]: read-only, latest average.
  - Unmapped reads return 0; unmapped writes are ignored; writes to STATUS and IN are ignored.
- Drive: channel c drives out_reg[c] when dir[c]=1, else hi-Z. dir and out_reg update on the edge sampling wr_en, so the pin changes one cycle after the write.
- Input path:
  - Two-flop synchroniser per channel; the pin value reaches the sync output 2 cycles later.
  - Sampling is unconditional, so driven channels read back their own pin.
- Prescaler: counter 0..PRESCALE-1; tick asserts in the cycle where count==PRESCALE-1, then wraps to 0. PRESCALE=1 means a tick every cycle.
- Averaging FSM, shared by all channels and synchronous on tick:
  - ACCUM: acc[c] += sync[c]. Accumulator width is BITS+AVG_LOG2, so it cannot overflow. The sample counter increments.
  - When the sample counter reaches 2^AVG_LOG2-1 on a tick, that same tick does all of: in_reg[c] <= (acc[c]+sync[c]) >> AVG_LOG2 (truncating); acc cleared; counter to 0; valid[c] set.
- Reads:
  - One-cycle latency: rd_en/addr sampled at edge N; rdata/rvalid valid after edge N+1 and held for one cycle.
  - rdata returns 0 when rvalid=0.
  - Reading STATUS returns the flags and clears them.
  - If a valid set coincides with a STATUS read, the set wins: flag = 1, returned word shows the pre-set value.
- wr_en and rd_en in the same cycle: both performed. A read of the address being written returns the old value.
- Reset (any time, including mid-accumulation):
  - dir=0 (all hi-Z), out_reg=0, in_reg=0, acc=0, prescaler=0, sample counter=0, valid=0, rdata=0, rvalid=0, alarm=0.
  - Synchroniser flops cleared.
  - The first result appears PRESCALE*2^AVG_LOG2 cycles after release, plus sync latency.

Optional Feature:
- Macro: ANALOG_IO_LIMIT_EN.
- Defined:
  - Per-channel LO/HI threshold registers at 2+2*CHANNELS+2c (LO) and 3+2*CHANNELS+2c (HI), both read/write, reset LO=0 and HI=all-ones.
  - On each result update, alarm[c] <= (new in_reg[c] < LO[c]) | (new in_reg[c] > HI[c]), unsigned compare.
  - alarm[c] is held until the next result update.
- Undefined: alarm tied 0; those addresses behave as unmapped.

Decomposition:
- Shared package analog_io_pkg:
  - Register offset constants (DIR=0, STATUS=1, CH_BASE=2).
  - Function computing the OUT/IN/LO/HI address for channel c.
  - Accumulator-width helper.
- One natural sub-module: analog_io_chan. It holds the tristate driver, synchroniser, accumulator, in_reg and limit compare for one channel, instantiated CHANNELS times via generate.
- Prescaler, sample counter and host decode stay in the top level.

Test Plan:
- Reset then read DIR, STATUS, OUT[0], IN[3] -> all rdata=0x0000 with rvalid one cycle after each rd_en; io_port all Z.
- Write DIR=0x0005, OUT[0]=0x1234, OUT[2]=0xBEEF -> ch0 pin=0x1234 and ch2 pin=0xBEEF from the cycle after each write; ch1/ch3 Z; reads return the written values.
- Defaults, ch1 pin held at 0x0100 externally -> valid[1] rises exactly 32 cycles after reset release plus sync latency; IN[1]=0x0100.
- ch1 pin alternating 0x0003/0x0006 per tick -> IN[1]=0x0004 (sum 18 >> 2).
- STATUS read in the same cycle a new result sets valid -> rdata shows bit clear, flag remains 1; the next STATUS read returns bit set, then clears.
- Assert rst mid-accumulation -> all outputs 0, pins Z; ANALOG_IO_LIMIT_EN build with LO[0]=0x0010 and input 0x0008 -> alarm[0]=1 after the next result.
